// File: rtl/fifo_serial_pkg.sv
// -----------------------------------------------------------------------------
// fifo_serial_pkg
// Shared definitions for fifo_serial_reader and its bit_timer.
//   state_t   : FSM state encoding (IDLE=0 .. STOP=6, 3 bits)
//   LINE_IDLE : serial line level while idle / during the stop bit
//   START_BIT : serial line level of the start bit
// -----------------------------------------------------------------------------
package fifo_serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/fifo_serial_reader_bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Counts clocks within one serial bit period. The count runs 0..bit_time-1 and
// wraps by itself; tick_last flags the final clock of each bit period.
// Ports:
//   clk       in  system clock, rising edge
//   rst       in  synchronous active-high reset
//   clear     in  hold the count at zero (used while no bit is on the line)
//   tick_last out high on the last clock of a bit period
// -----------------------------------------------------------------------------
module bit_timer #(
    parameter int bit_time       = 4,
    parameter int tick_cnt_width = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick_last
);

    localparam logic [tick_cnt_width-1:0] TICK_MAX = tick_cnt_width'(bit_time - 1);

    logic [tick_cnt_width-1:0] tick;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tick <= '0;
        end else if (tick == TICK_MAX) begin
            tick <= '0;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    assign tick_last = (tick == TICK_MAX);

endmodule

// File: rtl/fifo_serial_reader.sv
// -----------------------------------------------------------------------------
// fifo_serial_reader
// Consumer end of the synchronous FIFO. While enabled it pops one word at a
// time and sends it as a serial frame: start bit, data bits LSB first,
// optional even-parity bit, stop bit. Each bit lasts bit_time clocks.
//
// Optional feature: define FIFO_SERIAL_PARITY_EN to insert the parity bit.
//
// Ports:
//   clk             in  system clock, rising edge
//   rst             in  synchronous active-high reset
//   enable          in  permit starting new frames
//   stack_empty     in  FIFO empty flag
//   fifo_data       in  FIFO registered data out (valid the cycle after a pop)
//   read_from_stack out one-cycle FIFO pop request
//   serial_out      out serial line, idle high
//   busy            out high whenever the FSM is not in IDLE
//   word_done       out one-cycle pulse on the last clock of the stop bit
// -----------------------------------------------------------------------------
module fifo_serial_reader
    import fifo_serial_pkg::*;
#(
    parameter int word_width     = 4,
    parameter int bit_time       = 4,
    parameter int bit_cnt_width  = 3,
    parameter int tick_cnt_width = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  stack_empty,
    input  logic [word_width-1:0] fifo_data,
    output logic                  read_from_stack,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  word_done
);

    localparam logic [bit_cnt_width-1:0] LAST_IDX = bit_cnt_width'(word_width - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic [word_width-1:0]    shift_reg;
    logic [bit_cnt_width-1:0] bit_idx;
    logic                     tick_last;
    logic                     timer_clear;
`ifdef FIFO_SERIAL_PARITY_EN
    logic                     parity_bit;
`endif

    // The timer only runs while a bit is on the line, so every START begins
    // on a fresh bit period regardless of how long REQ/WAIT or IDLE lasted.
    assign timer_clear = (state == IDLE) || (state == REQ) || (state == WAIT);

    bit_timer #(
        .bit_time       (bit_time),
        .tick_cnt_width (tick_cnt_width)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .tick_last (tick_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
`ifdef FIFO_SERIAL_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == WAIT) begin
                // FIFO data out is valid one cycle after the pop request.
                shift_reg <= fifo_data;
                bit_idx   <= '0;
`ifdef FIFO_SERIAL_PARITY_EN
                parity_bit <= ^fifo_data;
`endif
            end else if ((state == DATA) && tick_last) begin
                shift_reg <= shift_reg >> 1;
                bit_idx   <= (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        serial_out      = LINE_IDLE;
        read_from_stack = 1'b0;
        word_done       = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !stack_empty) state_nxt = REQ;
            end
            REQ: begin
                read_from_stack = 1'b1;
                state_nxt       = WAIT;
            end
            WAIT: begin
                state_nxt = START;
            end
            START: begin
                serial_out = START_BIT;
                if (tick_last) state_nxt = DATA;
            end
            DATA: begin
                serial_out = shift_reg[0];
                if (tick_last && (bit_idx == LAST_IDX)) begin
`ifdef FIFO_SERIAL_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef FIFO_SERIAL_PARITY_EN
            PARITY: begin
                serial_out = parity_bit;
                if (tick_last) state_nxt = STOP;
            end
`endif
            STOP: begin
                serial_out = LINE_IDLE;
                if (tick_last) begin
                    word_done = 1'b1;
                    // Chain straight into the next pop so frames go out
                    // back to back with no idle bit between them.
                    state_nxt = (enable && !stack_empty) ? REQ : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_serial_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_serial_reader
// Self-checking bench for fifo_serial_reader. A queue-based FIFO model feeds
// the DUT; expected line levels come from a table of known frames and from a
// frame model built from the frame format (start, data LSB first, [parity],
// stop). Define FIFO_SERIAL_PARITY_EN for both DUT and bench to test parity.
// -----------------------------------------------------------------------------
module tb_fifo_serial_reader;

    localparam int WW = 4;
    localparam int BT = 4;
`ifdef FIFO_SERIAL_PARITY_EN
    localparam int FRAME_BITS = WW + 3;
`else
    localparam int FRAME_BITS = WW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          stack_empty = 1'b1;
    logic [WW-1:0] fifo_data = '0;
    logic          read_from_stack;
    logic          serial_out;
    logic          busy;
    logic          word_done;

    logic          push_en = 1'b0;
    logic [WW-1:0] push_word = '0;
    logic [WW-1:0] fifo_q[$];

    int checks = 0;
    int errors = 0;
    int proto_viol = 0;
    logic prev_read = 1'b0;

    fifo_serial_reader #(
        .word_width     (WW),
        .bit_time       (BT),
        .bit_cnt_width  (3),
        .tick_cnt_width (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .stack_empty     (stack_empty),
        .fifo_data       (fifo_data),
        .read_from_stack (read_from_stack),
        .serial_out      (serial_out),
        .busy            (busy),
        .word_done       (word_done)
    );

    always #5 clk = ~clk;

    // FIFO model: registered data out, empty flag updated at the clock edge.
    always @(posedge clk) begin
        if (read_from_stack) begin
            if (fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
            else proto_viol++;
        end
        if (push_en) fifo_q.push_back(push_word);
        stack_empty <= (fifo_q.size() == 0);
    end

    // Pop protocol watch: never two pops in a row, never a pop while empty.
    always @(negedge clk) begin
        if (!rst) begin
            if (read_from_stack && prev_read) proto_viol++;
            if (read_from_stack && stack_empty) proto_viol++;
        end
        prev_read = read_from_stack;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // Line level for each bit period of a frame, index 0 first on the wire.
    function automatic logic [7:0] model_line(input logic [WW-1:0] w);
        logic [7:0] l;
        l = '1;
        l[0] = 1'b0;
        for (int i = 0; i < WW; i++) l[1 + i] = w[i];
`ifdef FIFO_SERIAL_PARITY_EN
        l[WW + 1] = ^w;
`endif
        l[FRAME_BITS - 1] = 1'b1;
        return l;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic push(input logic [WW-1:0] w);
        push_en   = 1'b1;
        push_word = w;
        @(negedge clk);
        push_en   = 1'b0;
    endtask

    task automatic idle_check(input int n, input string nm);
        int bad_line = 0;
        int bad_busy = 0;
        int bad_read = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (serial_out !== 1'b1) bad_line++;
            if (busy !== 1'b0) bad_busy++;
            if (read_from_stack !== 1'b0) bad_read++;
        end
        check({nm, " idle line low cycles"}, bad_line, 0);
        check({nm, " idle busy cycles"}, bad_busy, 0);
        check({nm, " idle pop cycles"}, bad_read, 0);
    endtask

    // Waits (bounded) for the pop, then checks every clock of the frame.
    // Returns at the negedge of the frame's last clock.
    task automatic check_frame(input logic [7:0] exp, input int max_wait,
                               input int drop_en_at, input string nm);
        bit   got_pop = 0;
        int   wd_bad = 0;
        int   rd_extra = 0;
        int   busy_bad = 0;
        logic bad;
        logic got_lvl;
        int   k;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (read_from_stack === 1'b1) begin
                got_pop = 1;
                break;
            end
        end
        checks++;
        if (!got_pop) begin
            errors++;
            $display("FAIL %s pop: got none within %0d cycles, expected one", nm, max_wait);
            return;
        end
        @(negedge clk);
        if (read_from_stack !== 1'b0) rd_extra++;
        for (int b = 0; b < FRAME_BITS; b++) begin
            bad = 1'b0;
            got_lvl = exp[b];
            for (int t = 0; t < BT; t++) begin
                @(negedge clk);
                k = b * BT + t;
                if (k == drop_en_at) enable = 1'b0;
                if (serial_out !== exp[b] && !bad) begin
                    bad = 1'b1;
                    got_lvl = serial_out;
                end
                if (read_from_stack !== 1'b0) rd_extra++;
                if (word_done !== ((k == FRAME_BITS * BT - 1) ? 1'b1 : 1'b0)) wd_bad++;
                if (busy !== 1'b1) busy_bad++;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s bit%0d: line got %b expected %b", nm, b, got_lvl, exp[b]);
            end
        end
        check({nm, " word_done wrong cycles"}, wd_bad, 0);
        check({nm, " extra pops"}, rd_extra, 0);
        check({nm, " busy low cycles"}, busy_bad, 0);
    endtask

    typedef struct {
        logic [WW-1:0] word;
        logic [5:0]    line;   // start + data bits + stop, index 0 first
        logic          par;    // expected even-parity bit
        string         nm;
    } vec_t;

    vec_t          vecs[5];
    logic [7:0]    exp;
    logic [WW-1:0] w;
    logic [WW-1:0] words[$];
    int            n;

    initial begin
        vecs[0] = '{4'hA, 6'b110100, 1'b0, "frame_A"};
        vecs[1] = '{4'h3, 6'b100110, 1'b0, "frame_3"};
        vecs[2] = '{4'hC, 6'b111000, 1'b0, "frame_C"};
        vecs[3] = '{4'h5, 6'b101010, 1'b0, "frame_5"};
        vecs[4] = '{4'h7, 6'b101110, 1'b1, "frame_7"};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset serial_out", serial_out, 1);
        check("reset busy", busy, 0);
        check("reset read", read_from_stack, 0);
        check("reset word_done", word_done, 0);

        // Empty FIFO, enabled: nothing happens
        rst = 1'b0;
        enable = 1'b1;
        idle_check(50, "empty");

        // Table-driven single frames
        foreach (vecs[i]) begin
`ifdef FIFO_SERIAL_PARITY_EN
            exp = {1'b0, 1'b1, vecs[i].par, vecs[i].line[4:0]};
`else
            exp = {2'b00, vecs[i].line};
`endif
            enable = 1'b0;
            push(vecs[i].word);
            enable = 1'b1;
            check_frame(exp, 3, -1, vecs[i].nm);
            idle_check(3, vecs[i].nm);
        end

        // Back-to-back frames: second pop must follow the first stop bit directly
        enable = 1'b0;
        push(4'h3);
        push(4'hC);
        enable = 1'b1;
        check_frame(model_line(4'h3), 3, -1, "b2b_first");
        check_frame(model_line(4'hC), 1, -1, "b2b_second");
        idle_check(3, "b2b");

        // Enable dropped mid-DATA: frame completes, no further pop
        enable = 1'b0;
        push(4'h5);
        push(4'h9);
        enable = 1'b1;
        check_frame(model_line(4'h5), 3, 10, "en_drop");
        idle_check(20, "en_drop");
        check("en_drop word left in fifo", fifo_q.size(), 1);
        enable = 1'b1;
        check_frame(model_line(4'h9), 3, -1, "en_resume");
        idle_check(2, "en_resume");

        // Reset mid-DATA truncates the frame; next word then goes out whole
        enable = 1'b0;
        push(4'h6);
        push(4'hE);
        enable = 1'b1;
        n = 0;
        while (read_from_stack !== 1'b1 && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid pop seen", read_from_stack, 1);
        repeat (12) @(negedge clk);
        check("rst_mid busy before reset", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid serial_out", serial_out, 1);
        check("rst_mid busy", busy, 0);
        check("rst_mid read", read_from_stack, 0);
        rst = 1'b0;
        check_frame(model_line(4'hE), 3, -1, "rst_after");
        idle_check(2, "rst_after");

        // Randomized bursts checked against the frame model
        for (int r = 0; r < 8; r++) begin
            enable = 1'b0;
            n = $urandom_range(1, 3);
            words.delete();
            for (int j = 0; j < n; j++) begin
                w = WW'($urandom);
                words.push_back(w);
                push(w);
            end
            enable = 1'b1;
            for (int j = 0; j < n; j++) begin
                check_frame(model_line(words[j]), (j == 0) ? 3 : 1, -1, $sformatf("rand%0d_%0d", r, j));
            end
            idle_check(2, $sformatf("rand%0d", r));
        end

        check("pop protocol violations", proto_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
